// File: rtl/phase_change_detector_if.sv
// Period marker, oscillator inputs and per-neuron phase/change results of phase_change_detector.
interface phase_change_detector_if #(
  parameter int unsigned N       = 15,
  parameter int unsigned PHASE_W = 8
);
  logic                   full_tick;
  logic [N-1:0]           neuron_out;
  logic [N-1:0]           state_changed;
  logic [N*PHASE_W-1:0]   phase_out;
  logic [N-1:0]           phase_valid;

  modport master (
    output full_tick, neuron_out,
    input  state_changed, phase_out, phase_valid
  );

  modport slave (
    input  full_tick, neuron_out,
    output state_changed, phase_out, phase_valid
  );
endinterface

// File: rtl/phase_change_detector.sv
// Per-neuron oscillator phase measurement and period-to-period change flags.
// Optional macro PCD_SYNC_EN adds a 2-flop synchronizer on every neuron_out bit.
module phase_change_detector #(
  parameter int unsigned N       = 15,
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned TOL     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  phase_change_detector_if.slave  pcd_io
);

  localparam int unsigned CW = PHASE_W + 1;
  localparam logic [PHASE_W-1:0] PH_MAX = '1;

  logic                        tick;
  logic [N-1:0]                nrn;
  logic [N-1:0]                nrn_prev_q;
  logic [N-1:0]                rise;
  logic [PHASE_W-1:0]          phase_cnt_q, phase_cnt_d;
  logic [N-1:0]                cap_seen_q, cap_seen_d;
  logic [N-1:0][PHASE_W-1:0]   cap_phase_q, cap_phase_d;
  logic [N-1:0]                prev_valid_q, prev_valid_d;
  logic [N-1:0][PHASE_W-1:0]   prev_phase_q, prev_phase_d;
  logic [N-1:0]                state_changed_q, state_changed_d;
  logic                        first_done_q, first_done_d;

  assign tick = pcd_io.full_tick;

`ifdef PCD_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pcd_io.neuron_out;
      sync2_q <= sync1_q;
    end
  end

  assign nrn = sync2_q;
`else
  assign nrn = pcd_io.neuron_out;
`endif

  assign rise = nrn & ~nrn_prev_q;

  // Phase counter restarts on the tick edge and saturates instead of wrapping
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    if (tick) begin
      phase_cnt_d = '0;
    end else if (phase_cnt_q != PH_MAX) begin
      phase_cnt_d = phase_cnt_q + PHASE_W'(1);
    end
  end

  // First-edge capture during the period; commit and compare on the tick
  always_comb begin
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic [CW-1:0] diff;
    logic [N-1:0]  chg;

    cap_seen_d      = cap_seen_q;
    cap_phase_d     = cap_phase_q;
    prev_valid_d    = prev_valid_q;
    prev_phase_d    = prev_phase_q;
    state_changed_d = state_changed_q;
    first_done_d    = first_done_q;
    a               = '0;
    b               = '0;
    diff            = '0;
    chg             = '0;

    for (int i = 0; i < N; i++) begin
      a    = {1'b0, cap_phase_q[i]};
      b    = {1'b0, prev_phase_q[i]};
      diff = (a >= b) ? (a - b) : (b - a);
      if (tick) begin
        if (cap_seen_q[i] && prev_valid_q[i]) begin
          chg[i] = (diff > CW'(TOL));
        end else begin
          chg[i] = cap_seen_q[i] ^ prev_valid_q[i];
        end
        prev_phase_d[i] = cap_phase_q[i];
        prev_valid_d[i] = cap_seen_q[i];
        // An edge in the tick cycle opens the new period at phase 0
        cap_seen_d[i]   = rise[i];
        cap_phase_d[i]  = '0;
      end else if (rise[i] && !cap_seen_q[i]) begin
        cap_seen_d[i]  = 1'b1;
        cap_phase_d[i] = phase_cnt_q;
      end
    end

    if (tick) begin
      state_changed_d = first_done_q ? chg : '1;
      first_done_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nrn_prev_q      <= '0;
      phase_cnt_q     <= '0;
      cap_seen_q      <= '0;
      cap_phase_q     <= '0;
      prev_valid_q    <= '0;
      prev_phase_q    <= '0;
      state_changed_q <= '0;
      first_done_q    <= 1'b0;
    end else begin
      nrn_prev_q      <= nrn;
      phase_cnt_q     <= phase_cnt_d;
      cap_seen_q      <= cap_seen_d;
      cap_phase_q     <= cap_phase_d;
      prev_valid_q    <= prev_valid_d;
      prev_phase_q    <= prev_phase_d;
      state_changed_q <= state_changed_d;
      first_done_q    <= first_done_d;
    end
  end

  // Committed history doubles as the debug readout
  assign pcd_io.state_changed = state_changed_q;
  assign pcd_io.phase_out     = prev_phase_q;
  assign pcd_io.phase_valid   = prev_valid_q;

endmodule

// File: tb/tb_phase_change_detector.sv
// Directed bench for phase_change_detector: tolerance, vanish, tick edge, saturation, reset.
module tb_phase_change_detector;

  localparam int unsigned N       = 15;
  localparam int unsigned PHASE_W = 8;

  logic clk;
  logic rst_n;

  phase_change_detector_if #(.N(N), .PHASE_W(PHASE_W)) pcd ();

  phase_change_detector #(.N(N), .PHASE_W(PHASE_W), .TOL(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pcd_io (pcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          edge_a [N];
  int          edge_b [N];
  logic [14:0] tick_mask;
  logic [14:0] sc_hold;
  logic [119:0] exp_po;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_edges();
    for (int i = 0; i < N; i++) begin
      edge_a[i] = -1;
      edge_b[i] = -1;
    end
    tick_mask = '0;
    exp_po    = '0;
  endtask

  // len idle cycles (phase k in cycle k) followed by one full_tick cycle, then commit checks
  task automatic run_period(input string tag, input int len, input logic [14:0] exp_sc,
                            input logic [14:0] exp_pv);
    logic [14:0] nv;
    for (int k = 0; k < len; k++) begin
      for (int i = 0; i < N; i++) nv[i] = (edge_a[i] == k) || (edge_b[i] == k);
      pcd.full_tick  = 1'b0;
      pcd.neuron_out = nv;
      @(posedge clk); #1;
      if (k == len - 1) check({tag, "_hold_sc"}, 128'(pcd.state_changed), 128'(sc_hold));
    end
    pcd.full_tick  = 1'b1;
    pcd.neuron_out = tick_mask;
    @(posedge clk); #1;
    pcd.full_tick  = 1'b0;
    pcd.neuron_out = '0;
    check({tag, "_sc"}, 128'(pcd.state_changed), 128'(exp_sc));
    check({tag, "_pv"}, 128'(pcd.phase_valid), 128'(exp_pv));
    check({tag, "_po"}, 128'(pcd.phase_out), 128'(exp_po));
    sc_hold = exp_sc;
  endtask

  initial begin
    rst_n          = 1'b0;
    pcd.full_tick  = 1'b0;
    pcd.neuron_out = '0;
    sc_hold        = '0;
    clear_edges();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sc", 128'(pcd.state_changed), 128'd0);
    check("rst_pv", 128'(pcd.phase_valid), 128'd0);
    check("rst_po", 128'(pcd.phase_out), 128'd0);
    rst_n = 1'b1;

    // First commit forces all ones; neurons 0/3/5 captured
    edge_a[0] = 10; edge_a[3] = 20; edge_a[5] = 30;
    exp_po[0*8 +: 8] = 8'd10; exp_po[3*8 +: 8] = 8'd20; exp_po[5*8 +: 8] = 8'd30;
    run_period("p1", 99, 15'h7FFF, 15'h0029);

    // n3 moves by exactly TOL, n5 vanishes, n7 rises in the tick cycle
    clear_edges();
    edge_a[0] = 10; edge_a[3] = 22; tick_mask[7] = 1'b1;
    exp_po[0*8 +: 8] = 8'd10; exp_po[3*8 +: 8] = 8'd22;
    run_period("p2", 99, 15'h0020, 15'h0009);

    // n3 moves by TOL+1, n5 still absent, n7 second edge at 40 ignored
    clear_edges();
    edge_a[0] = 10; edge_a[3] = 25; edge_b[7] = 40;
    exp_po[0*8 +: 8] = 8'd10; exp_po[3*8 +: 8] = 8'd25; exp_po[7*8 +: 8] = 8'd0;
    run_period("p3", 99, 15'h0088, 15'h0089);

    // n7 moves 0 -> 1, within tolerance
    clear_edges();
    edge_a[0] = 10; edge_a[3] = 25; edge_a[7] = 1;
    exp_po[0*8 +: 8] = 8'd10; exp_po[3*8 +: 8] = 8'd25; exp_po[7*8 +: 8] = 8'd1;
    run_period("p4", 99, 15'h0000, 15'h0089);

    // Long period: n9 edge at 300 saturates to 255
    clear_edges();
    edge_a[0] = 10; edge_a[3] = 25; edge_a[7] = 1; edge_a[9] = 300;
    exp_po[0*8 +: 8] = 8'd10; exp_po[3*8 +: 8] = 8'd25; exp_po[7*8 +: 8] = 8'd1;
    exp_po[9*8 +: 8] = 8'd255;
    run_period("p5", 399, 15'h0200, 15'h0289);

    clear_edges();
    edge_a[0] = 10; edge_a[3] = 25; edge_a[7] = 1; edge_a[9] = 350;
    exp_po[0*8 +: 8] = 8'd10; exp_po[3*8 +: 8] = 8'd25; exp_po[7*8 +: 8] = 8'd1;
    exp_po[9*8 +: 8] = 8'd255;
    run_period("p6", 399, 15'h0000, 15'h0289);

    // Asynchronous reset in the middle of a period
    for (int k = 0; k < 50; k++) begin
      pcd.neuron_out = (k == 10) ? 15'h0001 : 15'h0000;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mrst_sc", 128'(pcd.state_changed), 128'd0);
    check("mrst_pv", 128'(pcd.phase_valid), 128'd0);
    check("mrst_po", 128'(pcd.phase_out), 128'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    sc_hold = '0;

    clear_edges();
    edge_a[0] = 10;
    exp_po[0*8 +: 8] = 8'd10;
    run_period("p7", 99, 15'h7FFF, 15'h0001);

    // Back-to-back ticks; n2 rises in the first of them
    clear_edges();
    tick_mask[2] = 1'b1;
    run_period("p8", 0, 15'h0001, 15'h0000);

    clear_edges();
    run_period("p9", 0, 15'h0004, 15'h0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phase_change_detector.md
# phase_change_detector

- Producer of the per-neuron `state_changed` flags that the system status monitor consumes.
- Measures each of 15 binary oscillator outputs' phase once per oscillation period, relative to the `full_tick` period marker.
- At each period boundary, compares every phase with the previous period's phase and raises that neuron's `state_changed` bit if it moved beyond a tolerance.
- The flags hold for the whole following period, so the monitor sees them while `full_tick` is low.

## Interface
- `N`, 15: neuron count (width of `neuron_out` / `state_changed`).
- `PHASE_W`, 8: phase counter width; phase saturates at 2^PHASE_W−1.
- `TOL`, 2: allowed absolute phase difference (clk cycles) still counted as "unchanged".
- `clk` input 1: single system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `full_tick` input 1: one-cycle pulse marking the end of one oscillation period and the start of the next.
- `neuron_out` input N: binary oscillator outputs, one per neuron.
- `state_changed` output N: per-neuron change flag for the current period; 1 = phase changed versus the previous period.
- `phase_out` output N*PHASE_W: last committed phase per neuron, neuron i at bits [i*PHASE_W +: PHASE_W]; for debug/readout.
- `phase_valid` output N: 1 = neuron had a rising edge in the last committed period.

## Operation
- **Phase counter.** `phase_cnt` (PHASE_W bits) is cleared on the edge where `full_tick`=1, otherwise increments, saturating at all-ones (no wrap).
- **Edge detect.** A rising edge of neuron i is `neuron_out[i]`=1 with its registered previous value 0.
- **Capture.** Only the first rising edge per period per neuron is captured.
  - `cap_phase[i]` ← (`full_tick` ? 0 : `phase_cnt`).
  - `cap_seen[i]` ← 1.
  - Later edges in the same period are ignored.
  - An edge in the `full_tick` cycle belongs to the new period with phase 0.
- **Commit**, on the `full_tick` edge, for each i:
  - If `cap_seen` and `prev_valid`: changed = |cap_phase − prev_phase| > TOL, computed at PHASE_W+1 bits unsigned-safe.
  - If `cap_seen` differs from `prev_valid`: changed = 1 (edge appeared or vanished).
  - If neither: changed = 0.
  - Then `prev_phase` ← `cap_phase`, `prev_valid` ← `cap_seen`.
  - `cap_seen` is cleared, unless an edge occurs in that same cycle, in which case it is set with phase 0.
- **Commit registers.** `state_changed`, `phase_out` and `phase_valid` are registered at commit and held constant until the next `full_tick`.
- **First period after reset.** There is no valid history. The first commit forces `state_changed` = all ones, so the monitor restarts its counters.
- **Reset values.**
  - `state_changed` = 0, `phase_out` = 0, `phase_valid` = 0.
  - `phase_cnt` = 0, all `cap_*` and `prev_*` = 0.
  - Internal flag `first_done` = 0.
- **Reset mid-period.** The in-progress capture is discarded; operation restarts as the first period after reset.
- **Back-to-back `full_tick`.** A period of length 1 is legal and each tick commits. Neurons with no edge commit `cap_seen` = 0.

## Timing
- `state_changed`, `phase_out` and `phase_valid` update one cycle after the `full_tick` cycle (registered), then stay stable for the period.
- Edge-to-capture latency is 1 cycle (prev-value register), or 3 cycles with `PCD_SYNC_EN`.
- The captured phase is the `phase_cnt` value in the cycle the edge is detected.
- No handshake: `full_tick` is sampled every cycle, no backpressure.

## Configuration
- **`PCD_SYNC_EN`:**
  - Defined: each `neuron_out` bit passes a 2-flop synchronizer (reset to 0) before edge detect, for asynchronous oscillator sources. All captured phases shift by +2 cycles, which is consistent and does not affect change detection.
  - Undefined: `neuron_out` is taken as synchronous to `clk` and used directly.

## Test plan
- **Reset then first period.** Release `rst_n`, `full_tick` every 100 cycles, neuron 0 rising at cycle 10 of each period. First commit → `state_changed`=15'h7FFF. Second commit → bit0=0, `phase_out[7:0]`=10.
- **Tolerance.** Neuron 3 edge at phase 20 then 22 → bit3=0. Then 25 → bit3=1 one cycle after `full_tick`, held until the next tick.
- **Edge vanishes.** Neuron 5 toggles in period k, then is held low in period k+1 → bit5=1, `phase_valid[5]`=0. Still low in period k+2 → bit5=0.
- **Edge on tick, plus multiple edges.** Neuron 7 rises in the `full_tick` cycle → captured phase 0 for the new period. A second edge at phase 40 in the same period is ignored.
- **Saturation.** 400-cycle period, neuron 9 edge at cycle 300 → `phase_out` = 255 (no wrap). Repeat at cycle 350 → bit9=0.
- **Async reset mid-period.** Assert `rst_n`=0 at cycle 50 of a period → all outputs 0 immediately. After release, the first commit yields all ones.
